// File: rtl/gb_audio_pkg.sv
// Shared types and constants for the audio serializer slice.
//   fmt_e           : serial framing format (left-justified or I2S)
//   level_w()       : width of a FIFO occupancy count for a given depth
//   WM8731_*        : default codec sample and slot widths
package gb_audio_pkg;

  typedef enum logic {
    FMT_LJ  = 1'b0,
    FMT_I2S = 1'b1
  } fmt_e;

  localparam int unsigned WM8731_SAMPLE_W = 16;
  localparam int unsigned WM8731_SLOT_W   = 32;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gb_audio_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   clock, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  : write request and data (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata shows the head entry
//   full, empty  : status from the registered count
//   level        : occupied entries
module gb_audio_fifo
  import gb_audio_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    empty    = (level_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/gb_audio_serializer.sv
// Stereo DAC serializer: buffers sample pairs, derives BCLK/LRCK from the
// system clock and shifts MSB-first data in left-justified or I2S framing.
//   clock, rst_n          : system clock, synchronous active-low reset
//   enable                : run serial clocks; low idles the lines
//   in_valid/in_ready     : sample pair handshake; in_left/in_right data
//   aud_bclk/aud_lrck     : bit clock and word select
//   aud_dacdat            : serial data, changes on BCLK falling edge
//   frame_start/underrun  : one-clock pulses at each frame boundary pop
//   fifo_level            : occupied FIFO entries
module gb_audio_serializer
  import gb_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = WM8731_SAMPLE_W,
  parameter int unsigned SLOT_W          = WM8731_SLOT_W,
  parameter int unsigned BCLK_DIV        = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned I2S_MODE        = 0,
  parameter int unsigned UNDERRUN_REPEAT = 1
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SAMPLE_W-1:0]            in_left,
  input  logic [SAMPLE_W-1:0]            in_right,
  output logic                           aud_bclk,
  output logic                           aud_lrck,
  output logic                           aud_dacdat,
  output logic                           frame_start,
  output logic                           underrun,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);

  localparam fmt_e        FMT       = (I2S_MODE != 0) ? FMT_I2S : FMT_LJ;
  localparam int unsigned FRAME     = 2 * SLOT_W;
  localparam int unsigned BIT_W     = $clog2(FRAME);
  localparam int unsigned DIV_W     = $clog2(BCLK_DIV);
  localparam logic        IDLE_LRCK = (FMT == FMT_I2S);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                started_q, started_d;
  logic                bclk_q, bclk_d;
  logic                lrck_q, lrck_d;
  logic                dacdat_q, dacdat_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] cur_l_q, cur_l_d;
  logic [SAMPLE_W-1:0] cur_r_q, cur_r_d;
  logic [SAMPLE_W-1:0] prev_r_q, prev_r_d;

  logic                  fall, boundary;
  logic [BIT_W-1:0]      s, p;
  logic [SAMPLE_W-1:0]   smp, shifted;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_rdata;

  gb_audio_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata ({in_left, in_right}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    started_d     = started_q;
    bclk_d        = bclk_q;
    lrck_d        = lrck_q;
    dacdat_d      = dacdat_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    cur_l_d       = cur_l_q;
    cur_r_d       = cur_r_q;
    prev_r_d      = prev_r_q;
    fifo_pop      = 1'b0;
    fall          = 1'b0;
    boundary      = 1'b0;
    s             = '0;
    p             = '0;
    smp           = '0;
    shifted       = '0;

    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      started_d = 1'b0;
      bclk_d    = 1'b0;
      lrck_d    = IDLE_LRCK;
      dacdat_d  = 1'b0;
    end else begin
      fall      = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
      div_cnt_d = fall ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d    = (div_cnt_d >= DIV_W'(BCLK_DIV / 2));
      if (fall) begin
        started_d = 1'b1;
        // The first event after enable holds bit 0 so it becomes a boundary.
        if (!started_q || bit_cnt_q == BIT_W'(FRAME - 1)) bit_cnt_d = '0;
        else                                                bit_cnt_d = bit_cnt_q + BIT_W'(1);
        boundary = (bit_cnt_d == '0);

        if (boundary) begin
          frame_start_d = 1'b1;
          prev_r_d      = cur_r_q;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_l_d  = fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
            cur_r_d  = fifo_rdata[SAMPLE_W-1:0];
          end else begin
            underrun_d = 1'b1;
            if (UNDERRUN_REPEAT == 0) begin
              cur_l_d = '0;
              cur_r_d = '0;
            end
          end
        end

        lrck_d = (bit_cnt_d < BIT_W'(SLOT_W)) ^ IDLE_LRCK;

        // I2S runs one bit behind the word select, so bit 0 still carries
        // the tail of the previous right sample.
        if (FMT == FMT_I2S) s = (bit_cnt_d == '0) ? BIT_W'(FRAME - 1) : bit_cnt_d - BIT_W'(1);
        else                s = bit_cnt_d;
        if (s < BIT_W'(SLOT_W)) begin
          p   = s;
          smp = cur_l_d;
        end else begin
          p   = s - BIT_W'(SLOT_W);
          smp = (FMT == FMT_I2S && bit_cnt_d == '0) ? prev_r_d : cur_r_d;
        end
        shifted  = smp << p;
        dacdat_d = (p < BIT_W'(SAMPLE_W)) && shifted[SAMPLE_W-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      started_q     <= 1'b0;
      bclk_q        <= 1'b0;
      lrck_q        <= IDLE_LRCK;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      cur_l_q       <= '0;
      cur_r_q       <= '0;
      prev_r_q      <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      started_q     <= started_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      cur_l_q       <= cur_l_d;
      cur_r_q       <= cur_r_d;
      prev_r_q      <= prev_r_d;
    end
  end

  assign aud_bclk    = bclk_q;
  assign aud_lrck    = lrck_q;
  assign aud_dacdat  = dacdat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_gb_audio_serializer.sv
// Three serializers (LJ/repeat, I2S/repeat, LJ/zero-fill) share one stimulus
// stream. Accepted pairs go into a scoreboard queue; a negedge monitor pops
// them at predicted frame boundaries and checks every output each cycle.
module tb_gb_audio_serializer;

  localparam int NDUT  = 3;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;

  logic [NDUT-1:0]      rdy_o, bclk_o, lrck_o, dat_o, fs_o, ur_o;
  logic [NDUT-1:0][2:0] lvl_o;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q[$];
  int          run_cnt = 0;
  bit          push_edge = 1'b0;
  logic [63:0] cur_frame [NDUT] = '{default: '0};
  logic        prev_last [NDUT] = '{default: 1'b0};

  always #5 clock = ~clock;

  function automatic bit i2s_of(input int d);
    return d == 1;
  endfunction

  function automatic bit rep_of(input int d);
    return d != 2;
  endfunction

  gb_audio_serializer #(.I2S_MODE(0), .UNDERRUN_REPEAT(1)) u_lj (
    .clock(clock), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy_o[0]),
    .in_left(in_left), .in_right(in_right), .aud_bclk(bclk_o[0]), .aud_lrck(lrck_o[0]),
    .aud_dacdat(dat_o[0]), .frame_start(fs_o[0]), .underrun(ur_o[0]), .fifo_level(lvl_o[0]));

  gb_audio_serializer #(.I2S_MODE(1), .UNDERRUN_REPEAT(1)) u_i2s (
    .clock(clock), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy_o[1]),
    .in_left(in_left), .in_right(in_right), .aud_bclk(bclk_o[1]), .aud_lrck(lrck_o[1]),
    .aud_dacdat(dat_o[1]), .frame_start(fs_o[1]), .underrun(ur_o[1]), .fifo_level(lvl_o[1]));

  gb_audio_serializer #(.I2S_MODE(0), .UNDERRUN_REPEAT(0)) u_zero (
    .clock(clock), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy_o[2]),
    .in_left(in_left), .in_right(in_right), .aud_bclk(bclk_o[2]), .aud_lrck(lrck_o[2]),
    .aud_dacdat(dat_o[2]), .frame_start(fs_o[2]), .underrun(ur_o[2]), .fifo_level(lvl_o[2]));

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
  endtask

  // Monitor / reference model. Runs mid-cycle; enable and rst_n hold the
  // values the DUTs sampled at the preceding rising edge.
  always @(negedge clock) begin
    int          avail;
    int          b;
    logic [31:0] pair;
    logic        fs_exp, ur_exp, eb, el, ed;

    if (!rst_n) begin
      run_cnt = 0;
      exp_q.delete();
      for (int d = 0; d < NDUT; d++) begin
        cur_frame[d] = '0;
        prev_last[d] = 1'b0;
      end
    end else if (!enable) begin
      run_cnt = 0;
    end else begin
      run_cnt++;
    end

    // Bit events every 4 clocks starting 4 clocks after enable; 64 bits/frame.
    fs_exp = 1'b0;
    ur_exp = 1'b0;
    if (run_cnt >= 4 && run_cnt % 4 == 0 && ((run_cnt / 4 - 1) % 64) == 0) begin
      fs_exp = 1'b1;
      avail = exp_q.size() - (push_edge ? 1 : 0);
      if (avail > 0) begin
        pair = exp_q.pop_front();
        for (int d = 0; d < NDUT; d++) begin
          prev_last[d] = cur_frame[d][0];
          cur_frame[d] = {pair[31:16], 16'h0000, pair[15:0], 16'h0000};
        end
      end else begin
        ur_exp = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
          prev_last[d] = cur_frame[d][0];
          if (!rep_of(d)) cur_frame[d] = '0;
        end
      end
    end

    for (int d = 0; d < NDUT; d++) begin
      eb = 1'b0;
      el = i2s_of(d);
      ed = 1'b0;
      if (run_cnt > 0) begin
        eb = (run_cnt % 4) >= 2;
        if (run_cnt >= 4) begin
          b  = (run_cnt / 4 - 1) % 64;
          el = (b < 32) ^ i2s_of(d);
          if (!i2s_of(d)) ed = cur_frame[d][63 - b];
          else if (b == 0) ed = prev_last[d];
          else             ed = cur_frame[d][64 - b];
        end
      end
      chk("outs{bclk,lrck,dat,fs,ur}", d,
          32'({bclk_o[d], lrck_o[d], dat_o[d], fs_o[d], ur_o[d]}),
          32'({eb, el, ed, fs_exp, ur_exp}));
      chk("fifo_level", d, 32'(lvl_o[d]), 32'(exp_q.size()));
    end
  end

  // One clock of stimulus, called just after a falling edge.
  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r);
    bit rdy;
    in_valid = v;
    in_left  = l;
    in_right = r;
    rdy = exp_q.size() < DEPTH;
    for (int d = 0; d < NDUT; d++) chk("in_ready", d, 32'(rdy_o[d]), 32'(rdy));
    @(posedge clock);
    push_edge = v && rdy && rst_n;
    if (push_edge) exp_q.push_back({l, r});
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
  endtask

  // Advance until the next rising edge is a frame boundary.
  task automatic run_to_boundary();
    for (int i = 0; i < 600; i++) begin
      if (run_cnt >= 3 && (run_cnt - 3) % 256 == 0) return;
      step(1'b0, 16'h0000, 16'h0000);
    end
    checks++;
    $display("FAIL run_to_boundary: no boundary within 600 clocks, run_cnt=%0d expected boundary", run_cnt);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    rst_n = 1'b1;
    idle(500);

    // Known pair, then three frames: one real, two underruns.
    step(1'b1, 16'hA5C3, 16'h0F0F);
    enable = 1'b1;
    idle(3 * 256 + 8);

    // Back-pressure with serial clocks stopped.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 16'($urandom));
    idle(4);

    // First pop takes level to 3, then push and pop in the same cycle.
    enable = 1'b1;
    run_to_boundary();
    step(1'b0, 16'h0000, 16'h0000);
    run_to_boundary();
    step(1'b1, 16'($urandom), 16'($urandom));

    // Random traffic across several frames.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) == 0, 16'($urandom), 16'($urandom));

    // Reset in the middle of a frame at bit 20.
    for (int i = 0; i < 600; i++) begin
      if (run_cnt >= 4 && ((run_cnt / 4 - 1) % 64) == 20) break;
      step(1'b0, 16'h0000, 16'h0000);
    end
    rst_n = 1'b0;
    step(1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 199) == 0, 16'($urandom), 16'($urandom));

    // Enable toggling with random traffic.
    for (int k = 0; k < 3; k++) begin
      enable = 1'b0;
      for (int i = 0; i < 20 + int'($urandom_range(0, 30)); i++)
        step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
      enable = 1'b1;
      for (int i = 0; i < 300 + int'($urandom_range(0, 300)); i++)
        step($urandom_range(0, 149) == 0, 16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
